// File: rtl/dram_bridge_if.sv
// rtl/dram_bridge_if.sv - core-side and DRAM app-side signal bundle for dram_bridge
interface dram_bridge_if;
  logic         valid_dram;
  logic         rw_dram;
  logic [26:0]  addr_dram;
  logic [31:0]  din_dram;
  logic [31:0]  dout_dram;
  logic         ready_dram;
  logic         busy;
  logic         init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  modport master (
    output valid_dram, rw_dram, addr_dram, din_dram,
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  dout_dram, ready_dram, busy,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport slave (
    input  valid_dram, rw_dram, addr_dram, din_dram,
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output dout_dram, ready_dram, busy,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/dram_bridge.sv
// rtl/dram_bridge.sv - 32-bit core port to 128-bit DRAM app interface bridge
// Optional single-line read buffer with write-through: define DRAM_READ_BUFFER_EN.
module dram_bridge (
  input logic         clk,
  input logic         rstn,
  dram_bridge_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_REQ, RESP} state_e;

  state_e        state_q;
  logic [26:1]   addr_q;
  logic [31:0]   dout_q;
  logic          ready_q;
  logic [26:0]   app_addr_q;
  logic [2:0]    app_cmd_q;
  logic          app_en_q;
  logic [127:0]  wdf_data_q;
  logic [15:0]   wdf_mask_q;
  logic          wdf_wren_q;
  logic          cmd_done_q;
  logic          wdf_done_q;

  logic [1:0]    lane_w;
  logic          cmd_hs, wdf_hs, cmd_fin, wdf_fin;
  logic          buf_hit;
  logic [31:0]   buf_word;

  assign lane_w  = addr_q[2:1];
  assign cmd_hs  = (state_q == WR_REQ) && app_en_q && bus.app_rdy;
  assign wdf_hs  = (state_q == WR_REQ) && wdf_wren_q && bus.app_wdf_rdy;
  assign cmd_fin = cmd_done_q || cmd_hs;
  assign wdf_fin = wdf_done_q || wdf_hs;

`ifdef DRAM_READ_BUFFER_EN
  logic          buf_valid_q;
  logic [23:0]   buf_tag_q;
  logic [127:0]  buf_data_q;

  assign buf_hit  = buf_valid_q && (buf_tag_q == bus.addr_dram[26:3]);
  assign buf_word = buf_data_q[{bus.addr_dram[2:1], 5'b0} +: 32];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (state_q == RD_WAIT && bus.app_rd_data_valid) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= addr_q[26:3];
      buf_data_q  <= bus.app_rd_data;
    end else if (state_q == WR_REQ && cmd_fin && wdf_fin && buf_valid_q &&
                 buf_tag_q == addr_q[26:3]) begin
      buf_data_q[{lane_w, 5'b0} +: 32] <= wdf_data_q[31:0];
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      dout_q     <= '0;
      ready_q    <= 1'b0;
      app_addr_q <= '0;
      app_cmd_q  <= '0;
      app_en_q   <= 1'b0;
      wdf_data_q <= '0;
      wdf_mask_q <= '0;
      wdf_wren_q <= 1'b0;
      cmd_done_q <= 1'b0;
      wdf_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_dram && bus.init_calib_complete) begin
            addr_q <= bus.addr_dram[26:1];
            if (bus.rw_dram) begin
              state_q    <= WR_REQ;
              app_en_q   <= 1'b1;
              app_cmd_q  <= 3'b000;
              app_addr_q <= {bus.addr_dram[26:3], 3'b000};
              wdf_wren_q <= 1'b1;
              wdf_data_q <= {4{bus.din_dram}};
              wdf_mask_q <= ~(16'hF << {bus.addr_dram[2:1], 2'b00});
            end else if (buf_hit) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              dout_q  <= buf_word;
            end else begin
              state_q    <= RD_CMD;
              app_en_q   <= 1'b1;
              app_cmd_q  <= 3'b001;
              app_addr_q <= {bus.addr_dram[26:3], 3'b000};
            end
          end
        end
        RD_CMD: begin
          if (bus.app_rdy) begin
            app_en_q <= 1'b0;
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.app_rd_data_valid) begin
            dout_q  <= bus.app_rd_data[{lane_w, 5'b0} +: 32];
            ready_q <= 1'b1;
            state_q <= RESP;
          end
        end
        WR_REQ: begin
          // command and data channels finish independently, in any order
          if (cmd_hs) begin
            app_en_q   <= 1'b0;
            cmd_done_q <= 1'b1;
          end
          if (wdf_hs) begin
            wdf_wren_q <= 1'b0;
            wdf_done_q <= 1'b1;
          end
          if (cmd_fin && wdf_fin) begin
            cmd_done_q <= 1'b0;
            wdf_done_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          ready_q    <= 1'b0;
          app_addr_q <= '0;
          app_cmd_q  <= '0;
          wdf_data_q <= '0;
          wdf_mask_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dout_dram    = dout_q;
  assign bus.ready_dram   = ready_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.app_addr     = app_addr_q;
  assign bus.app_cmd      = app_cmd_q;
  assign bus.app_en       = app_en_q;
  assign bus.app_wdf_data = wdf_data_q;
  assign bus.app_wdf_mask = wdf_mask_q;
  assign bus.app_wdf_wren = wdf_wren_q;
  assign bus.app_wdf_end  = wdf_wren_q;

endmodule

// File: tb/tb_dram_bridge.sv
// tb/tb_dram_bridge.sv - directed self-checking bench for dram_bridge
module tb_dram_bridge;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  dram_bridge_if bus ();
  dram_bridge dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] RD_LINE = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  initial begin
    bus.valid_dram = 0; bus.rw_dram = 0; bus.addr_dram = '0; bus.din_dram = '0;
    bus.init_calib_complete = 1; bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 0;

    // reset state
    tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.ready_dram, 0);
    check("rst_dout", bus.dout_dram, 0);
    check("rst_app_en", bus.app_en, 0);
    check("rst_wren", bus.app_wdf_wren, 0);
    check("rst_app_addr", bus.app_addr, 0);
    check("rst_mask", bus.app_wdf_mask, 0);
    check("rst_wdata", bus.app_wdf_data, 0);
    rstn = 1;
    tick();

    // read 0x10, lane 0, data valid 3 cycles after command
    bus.valid_dram = 1; bus.rw_dram = 0; bus.addr_dram = 27'h0000010; bus.app_rdy = 1;
    tick();
    check("rd_app_en", bus.app_en, 1);
    check("rd_app_cmd", bus.app_cmd, 3'b001);
    check("rd_app_addr", bus.app_addr, 27'h0000010);
    check("rd_busy", bus.busy, 1);
    bus.valid_dram = 0; bus.addr_dram = 27'h7FFFFFE;
    tick();
    check("rd_en_drop", bus.app_en, 0);
    check("rd_addr_latched", bus.app_addr, 27'h0000010);
    tick();
    check("rd_wait_noready", bus.ready_dram, 0);
    bus.app_rd_data = RD_LINE; bus.app_rd_data_valid = 1;
    tick();
    check("rd_ready", bus.ready_dram, 1);
    check("rd_dout", bus.dout_dram, 32'h11111111);
    bus.app_rd_data_valid = 0;
    tick();
    check("rd_ready_once", bus.ready_dram, 0);
    check("rd_idle", bus.busy, 0);
    check("rd_idle_addr", bus.app_addr, 0);

    // write 0x24 (lane 2), app_rdy low for 2 cycles
    bus.app_rdy = 0; bus.app_wdf_rdy = 1;
    bus.valid_dram = 1; bus.rw_dram = 1; bus.addr_dram = 27'h0000024; bus.din_dram = 32'hDEADBEEF;
    tick();
    check("wr_app_en", bus.app_en, 1);
    check("wr_app_cmd", bus.app_cmd, 3'b000);
    check("wr_wren", bus.app_wdf_wren, 1);
    check("wr_end", bus.app_wdf_end, 1);
    check("wr_mask", bus.app_wdf_mask, 16'hF0FF);
    check("wr_data", bus.app_wdf_data, {4{32'hDEADBEEF}});
    check("wr_app_addr", bus.app_addr, 27'h0000020);
    bus.valid_dram = 0; bus.din_dram = 32'h0;
    tick();
    check("wr_wren_drop", bus.app_wdf_wren, 0);
    check("wr_en_held", bus.app_en, 1);
    check("wr_data_latched", bus.app_wdf_data, {4{32'hDEADBEEF}});
    tick();
    check("wr_no_ready_yet", bus.ready_dram, 0);
    bus.app_rdy = 1;
    tick();
    check("wr_ready", bus.ready_dram, 1);
    check("wr_en_drop", bus.app_en, 0);
    check("wr_dout_kept", bus.dout_dram, 32'h11111111);
    tick();
    check("wr_ready_once", bus.ready_dram, 0);
    check("wr_idle_mask", bus.app_wdf_mask, 0);

    // calibration not complete: request must wait
    bus.init_calib_complete = 0;
    bus.valid_dram = 1; bus.rw_dram = 0; bus.addr_dram = 27'h0000046;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("cal_app_en", bus.app_en, 0);
      check("cal_busy", bus.busy, 0);
    end
    bus.init_calib_complete = 1;
    tick();
    check("cal_accept_en", bus.app_en, 1);
    check("cal_accept_addr", bus.app_addr, 27'h0000040);
    bus.valid_dram = 0;
    tick();
    bus.app_rd_data = RD_LINE; bus.app_rd_data_valid = 1;
    tick();
    check("lane3_dout", bus.dout_dram, 32'h44444444);
    bus.app_rd_data_valid = 0;
    tick();

    // back-to-back: valid held through RESP, both handshakes same cycle
    bus.valid_dram = 1; bus.rw_dram = 1; bus.addr_dram = 27'h0000008; bus.din_dram = 32'hCAFEF00D;
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    tick();
    check("b2b_mask", bus.app_wdf_mask, 16'hFFF0);
    tick();
    check("b2b_ready1", bus.ready_dram, 1);
    tick();
    check("b2b_idle", bus.busy, 0);
    tick();
    check("b2b_second_busy", bus.busy, 1);
    check("b2b_second_en", bus.app_en, 1);
    bus.valid_dram = 0;
    tick();
    check("b2b_ready2", bus.ready_dram, 1);
    tick();
    check("b2b_end_idle", bus.busy, 0);

    // reset during RD_WAIT aborts the read
    bus.valid_dram = 1; bus.rw_dram = 0; bus.addr_dram = 27'h0000020;
    tick();
    bus.valid_dram = 0;
    tick();
    check("abort_in_wait", bus.busy, 1);
    rstn = 0;
    tick();
    rstn = 1;
    bus.app_rd_data = RD_LINE; bus.app_rd_data_valid = 1;
    tick();
    check("abort_no_ready", bus.ready_dram, 0);
    check("abort_dout", bus.dout_dram, 0);
    check("abort_idle", bus.busy, 0);
    bus.app_rd_data_valid = 0;
    tick();
    check("abort_no_ready2", bus.ready_dram, 0);

    // same-line reads: buffer hit when enabled, DRAM command otherwise
    bus.app_rd_data = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    bus.valid_dram = 1; bus.rw_dram = 0; bus.addr_dram = 27'h0000100;
    tick();
    bus.valid_dram = 0;
    tick();
    bus.app_rd_data_valid = 1;
    tick();
    check("line_rd_dout", bus.dout_dram, 32'hA0A0A0A0);
    bus.app_rd_data_valid = 0;
    tick();
    bus.valid_dram = 1; bus.addr_dram = 27'h0000102;
    tick();
    bus.valid_dram = 0;
`ifdef DRAM_READ_BUFFER_EN
    check("hit_no_en", bus.app_en, 0);
    check("hit_ready", bus.ready_dram, 1);
    check("hit_dout", bus.dout_dram, 32'hA1A1A1A1);
    tick();
    bus.valid_dram = 1; bus.rw_dram = 1; bus.din_dram = 32'h12345678;
    tick();
    bus.valid_dram = 0;
    tick();
    check("wt_ready", bus.ready_dram, 1);
    tick();
    bus.valid_dram = 1; bus.rw_dram = 0;
    tick();
    bus.valid_dram = 0;
    check("wt_hit_no_en", bus.app_en, 0);
    check("wt_hit_ready", bus.ready_dram, 1);
    check("wt_hit_dout", bus.dout_dram, 32'h12345678);
    tick();
`else
    check("nobuf_en", bus.app_en, 1);
    check("nobuf_no_ready", bus.ready_dram, 0);
    tick();
    bus.app_rd_data_valid = 1;
    tick();
    check("nobuf_ready", bus.ready_dram, 1);
    check("nobuf_dout", bus.dout_dram, 32'hA1A1A1A1);
    bus.app_rd_data_valid = 0;
    tick();
`endif
    check("final_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
